// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared control width, bubble control word, per-boundary bundle widths and occupancy encoding.
// Revision 1.0
package pipe_pkg;

    localparam int PIPE_CTRL_W = 17;
    localparam logic [PIPE_CTRL_W-1:0] PIPE_NOP_CTRL = '0;

    // Bundle widths packed by the enclosing stages
    localparam int REG_EXE_DATA_W = 4 + 4 + 32*7;
    localparam int EXE_MEM_DATA_W = 5 + 32*2;
    localparam int MEM_WB_DATA_W  = 5 + 32;

    typedef enum logic [1:0] {
        OCC_EMPTY     = 2'd0,
        OCC_FULL      = 2'd1,
        OCC_SKID_FULL = 2'd2
    } occ_state_e;

    function automatic logic [1:0] occ_count(input occ_state_e s);
        case (s)
            OCC_FULL:      return 2'd1;
            OCC_SKID_FULL: return 2'd2;
            default:       return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// pipe_stage_reg_if: upstream/downstream handshake, stall/flush and occupancy of one stage register.
// Revision 1.0
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int CTRL_W = PIPE_CTRL_W,
    parameter int DATA_W = 200
);
    logic              i_stall;
    logic              i_flush;
    logic              i_valid;
    logic              o_ready;
    logic [CTRL_W-1:0] i_ctrl;
    logic [DATA_W-1:0] i_data;
    logic              o_valid;
    logic              i_ready;
    logic [CTRL_W-1:0] o_ctrl;
    logic [DATA_W-1:0] o_data;
    logic [1:0]        o_count;

    modport slave (
        input  i_stall, i_flush, i_valid, i_ctrl, i_data, i_ready,
        output o_ready, o_valid, o_ctrl, o_data, o_count
    );

    modport master (
        output i_stall, i_flush, i_valid, i_ctrl, i_data, i_ready,
        input  o_ready, o_valid, o_ctrl, o_data, o_count
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// pipe_skid_buf: 2-entry storage (main + skid) with occupancy FSM and registered ready.
// Revision 1.0
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter int                DATA_W   = 200,
    parameter logic [CTRL_W-1:0] NOP_CTRL = PIPE_NOP_CTRL
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                flush,
    input  wire                acc,
    input  wire                dep,
    input  wire   [CTRL_W-1:0] ctrl,
    input  wire   [DATA_W-1:0] data,
    output logic               valid,
    output logic  [CTRL_W-1:0] head_ctrl,
    output logic  [DATA_W-1:0] head_data,
    output logic  [1:0]        count,
    output logic               ready
);

    occ_state_e        state;
    occ_state_e        state_next;
    logic              load_in;
    logic              load_from_skid;
    logic              load_skid;
    logic              ready_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    always_comb begin
        state_next     = state;
        load_in        = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (acc) begin
                    state_next = OCC_FULL;
                    load_in    = 1'b1;
                end
            end
            OCC_FULL: begin
                if (acc && dep) begin
                    load_in = 1'b1;
                end else if (acc) begin
                    state_next = OCC_SKID_FULL;
                    load_skid  = 1'b1;
                end else if (dep) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_SKID_FULL: begin
                if (dep) begin
                    state_next     = OCC_FULL;
                    load_from_skid = 1'b1;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
        // Flush wins over any same-cycle transfer; stored data is left as-is
        if (flush) begin
            state_next     = OCC_EMPTY;
            load_in        = 1'b0;
            load_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= OCC_EMPTY;
            ready_q   <= 1'b0;
            main_ctrl <= NOP_CTRL;
            main_data <= '0;
            skid_ctrl <= NOP_CTRL;
            skid_data <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != OCC_SKID_FULL);
            if (load_in) begin
                main_ctrl <= ctrl;
                main_data <= data;
            end else if (load_from_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= ctrl;
                skid_data <= data;
            end
        end
    end

    assign valid     = (state != OCC_EMPTY);
    assign head_ctrl = main_ctrl;
    assign head_data = main_data;
    assign count     = occ_count(state);
    assign ready     = ready_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// pipe_stage_reg: parametrised pipeline stage register with stall, flush and optional skid buffer.
// Revision 1.0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter int                DATA_W   = 200,
    parameter int                SKID     = 1,
    parameter logic [CTRL_W-1:0] NOP_CTRL = PIPE_NOP_CTRL
) (
    input  wire              clk,
    input  wire              rst_n,
    pipe_stage_reg_if.slave  bus
);

    logic              acc;
    logic              dep;
    logic              ready;
    logic              held_valid;
    logic [CTRL_W-1:0] held_ctrl;
    logic [DATA_W-1:0] held_data;
    logic [1:0]        count;

    assign acc = bus.i_valid & ready;
    assign dep = held_valid & bus.i_ready & ~bus.i_stall;

    generate
        if (SKID != 0) begin : g_skid
            logic buf_ready;

            pipe_skid_buf #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .NOP_CTRL (NOP_CTRL)
            ) u_skid_buf (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (bus.i_flush),
                .acc       (acc),
                .dep       (dep),
                .ctrl      (bus.i_ctrl),
                .data      (bus.i_data),
                .valid     (held_valid),
                .head_ctrl (held_ctrl),
                .head_data (held_data),
                .count     (count),
                .ready     (buf_ready)
            );

            // Registered ready: no path from downstream i_ready to upstream o_ready
            assign ready = buf_ready & ~bus.i_stall;
        end else begin : g_plain
            logic              valid_q;
            logic [CTRL_W-1:0] ctrl_q;
            logic [DATA_W-1:0] data_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    ctrl_q  <= NOP_CTRL;
                    data_q  <= '0;
                end else if (bus.i_flush) begin
                    valid_q <= 1'b0;
                end else if (acc) begin
                    valid_q <= 1'b1;
                    ctrl_q  <= bus.i_ctrl;
                    data_q  <= bus.i_data;
                end else if (dep) begin
                    valid_q <= 1'b0;
                end
            end

            assign held_valid = valid_q;
            assign held_ctrl  = ctrl_q;
            assign held_data  = data_q;
            assign count      = {1'b0, valid_q};
            assign ready      = (~valid_q | bus.i_ready) & ~bus.i_stall;
        end
    endgenerate

    assign bus.o_ready = ready;
    assign bus.o_valid = held_valid;
    assign bus.o_ctrl  = held_valid ? held_ctrl : NOP_CTRL;
    assign bus.o_data  = held_data;
    assign bus.o_count = count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg: directed bench driving a SKID=1 and a SKID=0 stage from shared stimulus.
// Revision 1.0
module tb_pipe_stage_reg;

    localparam int          CW  = 17;
    localparam int          DW  = 200;
    localparam logic [16:0] NOP = 17'h0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, valid_in, ready_in;
    logic [CW-1:0] ctrl_in;
    logic [DW-1:0] data_in;
    int            total = 0;
    int            bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_s ();
    pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus_p ();

    assign bus_s.i_stall = stall;
    assign bus_s.i_flush = flush;
    assign bus_s.i_valid = valid_in;
    assign bus_s.i_ctrl  = ctrl_in;
    assign bus_s.i_data  = data_in;
    assign bus_s.i_ready = ready_in;
    assign bus_p.i_stall = stall;
    assign bus_p.i_flush = flush;
    assign bus_p.i_valid = valid_in;
    assign bus_p.i_ctrl  = ctrl_in;
    assign bus_p.i_data  = data_in;
    assign bus_p.i_ready = ready_in;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .NOP_CTRL(NOP)) u_dut_skid (
        .clk (clk), .rst_n (rst_n), .bus (bus_s)
    );
    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .NOP_CTRL(NOP)) u_dut_plain (
        .clk (clk), .rst_n (rst_n), .bus (bus_p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
        ctrl_in = 17'h1ABCD; data_in = DW'(5);
        tick();
        tick();
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_s: got %b want 0", bus_s.o_valid); end
        total++; if (bus_s.o_ctrl !== NOP) begin bad++; $display("FAIL rst_ctrl_s: got %h want %h", bus_s.o_ctrl, NOP); end
        total++; if (bus_s.o_count !== 2'd0) begin bad++; $display("FAIL rst_count_s: got %0d want 0", bus_s.o_count); end
        total++; if (bus_s.o_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_s: got %b want 0", bus_s.o_ready); end
        total++; if (bus_s.o_data !== DW'(0)) begin bad++; $display("FAIL rst_data_s: got %h want 0", bus_s.o_data); end
        total++; if (bus_p.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid_p: got %b want 0", bus_p.o_valid); end
        total++; if (bus_p.o_ctrl !== NOP) begin bad++; $display("FAIL rst_ctrl_p: got %h want %h", bus_p.o_ctrl, NOP); end
        rst_n = 1'b1; valid_in = 1'b0;
        tick();
        @(negedge clk);
        total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready_s: got %b want 1", bus_s.o_ready); end
        total++; if (bus_s.o_valid !== 1'b0) begin bad++; $display("FAIL rst_release_valid_s: got %b want 0", bus_s.o_valid); end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 8; i++) begin
            valid_in = 1'b1; ready_in = 1'b1; data_in = DW'(i); ctrl_in = CW'(32'h100 + i);
            @(negedge clk);
            total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_s[%0d]: got %b want 1", i, bus_s.o_ready); end
            total++; if (bus_p.o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready_p[%0d]: got %b want 1", i, bus_p.o_ready); end
            if (i > 1) begin
                total++; if (bus_s.o_data !== DW'(i-1)) begin bad++; $display("FAIL stream_data_s[%0d]: got %0h want %0h", i, bus_s.o_data, i-1); end
                total++; if (bus_p.o_data !== DW'(i-1)) begin bad++; $display("FAIL stream_data_p[%0d]: got %0h want %0h", i, bus_p.o_data, i-1); end
                total++; if (bus_s.o_count !== 2'd1) begin bad++; $display("FAIL stream_count_s[%0d]: got %0d want 1", i, bus_s.o_count); end
                total++; if (bus_p.o_count !== 2'd1) begin bad++; $display("FAIL stream_count_p[%0d]: got %0d want 1", i, bus_p.o_count); end
                total++; if (bus_s.o_ctrl !== CW'(32'h100 + i - 1)) begin bad++; $display("FAIL stream_ctrl_s[%0d]: got %h want %h", i, bus_s.o_ctrl, 32'h100 + i - 1); end
            end
            tick();
        end
        valid_in = 1'b0;
        @(negedge clk);
        total++; if (bus_s.o_data !== DW'(8)) begin bad++; $display("FAIL stream_last_s: got %0h want 8", bus_s.o_data); end
        total++; if (bus_p.o_data !== DW'(8)) begin bad++; $display("FAIL stream_last_p: got %0h want 8", bus_p.o_data); end
        tick();
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_s.o_count !== 2'd0) begin bad++; $display("FAIL stream_drain_s: got valid=%b count=%0d want 0/0", bus_s.o_valid, bus_s.o_count); end
        total++; if (bus_p.o_valid !== 1'b0 || bus_p.o_ctrl !== NOP) begin bad++; $display("FAIL stream_drain_p: got valid=%b ctrl=%h want 0/%h", bus_p.o_valid, bus_p.o_ctrl, NOP); end
        tick();
    endtask

    task automatic test_backpressure_skid();
        valid_in = 1'b1; ready_in = 1'b1; data_in = DW'(32'hA); ctrl_in = 17'h0AAAA;
        @(negedge clk);
        total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL bp_s_c1_ready: got %b want 1", bus_s.o_ready); end
        tick();
        valid_in = 1'b1; ready_in = 1'b0; data_in = DW'(32'hB); ctrl_in = 17'h0BBBB;
        @(negedge clk);
        total++; if (bus_s.o_data !== DW'(32'hA) || bus_s.o_valid !== 1'b1) begin bad++; $display("FAIL bp_s_c2_head: got data=%0h valid=%b want a/1", bus_s.o_data, bus_s.o_valid); end
        total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL bp_s_c2_ready: got %b want 1", bus_s.o_ready); end
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        total++; if (bus_s.o_count !== 2'd2) begin bad++; $display("FAIL bp_s_c3_count: got %0d want 2", bus_s.o_count); end
        total++; if (bus_s.o_ready !== 1'b0) begin bad++; $display("FAIL bp_s_c3_ready: got %b want 0", bus_s.o_ready); end
        total++; if (bus_s.o_data !== DW'(32'hA) || bus_s.o_ctrl !== 17'h0AAAA) begin bad++; $display("FAIL bp_s_c3_head: got data=%0h ctrl=%h want a/0aaaa", bus_s.o_data, bus_s.o_ctrl); end
        tick();
        ready_in = 1'b1;
        @(negedge clk);
        total++; if (bus_s.o_data !== DW'(32'hA) || bus_s.o_ready !== 1'b0) begin bad++; $display("FAIL bp_s_c4: got data=%0h ready=%b want a/0", bus_s.o_data, bus_s.o_ready); end
        tick();
        @(negedge clk);
        total++; if (bus_s.o_data !== DW'(32'hB) || bus_s.o_ctrl !== 17'h0BBBB) begin bad++; $display("FAIL bp_s_c5_head: got data=%0h ctrl=%h want b/0bbbb", bus_s.o_data, bus_s.o_ctrl); end
        total++; if (bus_s.o_count !== 2'd1 || bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL bp_s_c5_state: got count=%0d ready=%b want 1/1", bus_s.o_count, bus_s.o_ready); end
        tick();
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_s.o_count !== 2'd0 || bus_s.o_ctrl !== NOP) begin bad++; $display("FAIL bp_s_c6_empty: got valid=%b count=%0d ctrl=%h want 0/0/%h", bus_s.o_valid, bus_s.o_count, bus_s.o_ctrl, NOP); end
        tick();
    endtask

    task automatic test_stall();
        valid_in = 1'b1; ready_in = 1'b0; data_in = DW'(32'h55); ctrl_in = 17'h00055;
        tick();
        for (int k = 0; k < 3; k++) begin
            stall = 1'b1; valid_in = 1'b1; ready_in = 1'b1; data_in = DW'(32'h66); ctrl_in = 17'h00066;
            @(negedge clk);
            total++; if (bus_s.o_valid !== 1'b1 || bus_s.o_data !== DW'(32'h55) || bus_s.o_count !== 2'd1) begin bad++; $display("FAIL stall_hold_s[%0d]: got valid=%b data=%0h count=%0d want 1/55/1", k, bus_s.o_valid, bus_s.o_data, bus_s.o_count); end
            total++; if (bus_p.o_valid !== 1'b1 || bus_p.o_data !== DW'(32'h55)) begin bad++; $display("FAIL stall_hold_p[%0d]: got valid=%b data=%0h want 1/55", k, bus_p.o_valid, bus_p.o_data); end
            total++; if (bus_s.o_ready !== 1'b0 || bus_p.o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d]: got s=%b p=%b want 0/0", k, bus_s.o_ready, bus_p.o_ready); end
            total++; if (bus_s.o_ctrl !== 17'h00055) begin bad++; $display("FAIL stall_ctrl_s[%0d]: got %h want 00055", k, bus_s.o_ctrl); end
            tick();
        end
        stall = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        total++; if (bus_s.o_data !== DW'(32'h55) || bus_p.o_data !== DW'(32'h55)) begin bad++; $display("FAIL stall_release_data: got s=%0h p=%0h want 55", bus_s.o_data, bus_p.o_data); end
        total++; if (bus_s.o_ready !== 1'b1 || bus_p.o_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready: got s=%b p=%b want 1/1", bus_s.o_ready, bus_p.o_ready); end
        tick();
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_p.o_valid !== 1'b0 || bus_s.o_count !== 2'd0) begin bad++; $display("FAIL stall_depart: got s=%b p=%b count=%0d want 0/0/0", bus_s.o_valid, bus_p.o_valid, bus_s.o_count); end
        tick();
    endtask

    task automatic test_flush();
        valid_in = 1'b1; ready_in = 1'b0; data_in = DW'(1); ctrl_in = 17'h00011;
        tick();
        valid_in = 1'b1; data_in = DW'(2); ctrl_in = 17'h00022;
        @(negedge clk);
        total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL flush_pre_ready_s: got %b want 1", bus_s.o_ready); end
        tick();
        flush = 1'b1; valid_in = 1'b1; data_in = DW'(3); ctrl_in = 17'h00033;
        @(negedge clk);
        total++; if (bus_s.o_count !== 2'd2 || bus_s.o_ready !== 1'b0) begin bad++; $display("FAIL flush_pre_full_s: got count=%0d ready=%b want 2/0", bus_s.o_count, bus_s.o_ready); end
        tick();
        flush = 1'b1; valid_in = 1'b1; ready_in = 1'b1; data_in = DW'(9); ctrl_in = 17'h00099;
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_s.o_ctrl !== NOP || bus_s.o_count !== 2'd0) begin bad++; $display("FAIL flush_empty_s: got valid=%b ctrl=%h count=%0d want 0/%h/0", bus_s.o_valid, bus_s.o_ctrl, bus_s.o_count, NOP); end
        total++; if (bus_p.o_valid !== 1'b0 || bus_p.o_ctrl !== NOP) begin bad++; $display("FAIL flush_empty_p: got valid=%b ctrl=%h want 0/%h", bus_p.o_valid, bus_p.o_ctrl, NOP); end
        total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready_s: got %b want 1", bus_s.o_ready); end
        tick();
        flush = 1'b0; valid_in = 1'b1; ready_in = 1'b1; data_in = DW'(4); ctrl_in = 17'h00044;
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_p.o_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_acc: got s=%b p=%b want 0/0", bus_s.o_valid, bus_p.o_valid); end
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        total++; if (bus_s.o_data !== DW'(4) || bus_s.o_ctrl !== 17'h00044 || bus_s.o_count !== 2'd1) begin bad++; $display("FAIL flush_next_s: got data=%0h ctrl=%h count=%0d want 4/00044/1", bus_s.o_data, bus_s.o_ctrl, bus_s.o_count); end
        total++; if (bus_p.o_data !== DW'(4) || bus_p.o_valid !== 1'b1) begin bad++; $display("FAIL flush_next_p: got data=%0h valid=%b want 4/1", bus_p.o_data, bus_p.o_valid); end
        tick();
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_p.o_valid !== 1'b0) begin bad++; $display("FAIL flush_drain: got s=%b p=%b want 0/0", bus_s.o_valid, bus_p.o_valid); end
        tick();
    endtask

    task automatic test_backpressure_plain();
        valid_in = 1'b1; ready_in = 1'b1; data_in = DW'(32'hA); ctrl_in = 17'h0AAAA;
        @(negedge clk);
        total++; if (bus_p.o_ready !== 1'b1) begin bad++; $display("FAIL bp_p_c1_ready: got %b want 1", bus_p.o_ready); end
        tick();
        for (int k = 0; k < 2; k++) begin
            valid_in = 1'b1; ready_in = 1'b0; data_in = DW'(32'hB); ctrl_in = 17'h0BBBB;
            @(negedge clk);
            total++; if (bus_p.o_ready !== 1'b0) begin bad++; $display("FAIL bp_p_ready_low[%0d]: got %b want 0", k, bus_p.o_ready); end
            total++; if (bus_p.o_data !== DW'(32'hA) || bus_p.o_count !== 2'd1) begin bad++; $display("FAIL bp_p_hold[%0d]: got data=%0h count=%0d want a/1", k, bus_p.o_data, bus_p.o_count); end
            if (k == 1) begin
                #1 ready_in = 1'b1;
                #1;
                total++; if (bus_p.o_ready !== 1'b1) begin bad++; $display("FAIL bp_p_ready_follow: got %b want 1", bus_p.o_ready); end
            end
            tick();
        end
        valid_in = 1'b0; ready_in = 1'b1;
        @(negedge clk);
        total++; if (bus_p.o_data !== DW'(32'hB) || bus_p.o_valid !== 1'b1 || bus_p.o_count !== 2'd1) begin bad++; $display("FAIL bp_p_second: got data=%0h valid=%b count=%0d want b/1/1", bus_p.o_data, bus_p.o_valid, bus_p.o_count); end
        tick();
        @(negedge clk);
        total++; if (bus_p.o_valid !== 1'b0 || bus_p.o_count !== 2'd0) begin bad++; $display("FAIL bp_p_empty: got valid=%b count=%0d want 0/0", bus_p.o_valid, bus_p.o_count); end
        tick();
    endtask

    task automatic test_reset_mid();
        valid_in = 1'b1; ready_in = 1'b0; data_in = DW'(32'h77); ctrl_in = 17'h00077;
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b1 || bus_s.o_data !== DW'(32'h77)) begin bad++; $display("FAIL rmid_loaded_s: got valid=%b data=%0h want 1/77", bus_s.o_valid, bus_s.o_data); end
        tick();
        rst_n = 1'b1; valid_in = 1'b0;
        @(negedge clk);
        total++; if (bus_s.o_valid !== 1'b0 || bus_s.o_count !== 2'd0 || bus_s.o_ready !== 1'b0) begin bad++; $display("FAIL rmid_cleared_s: got valid=%b count=%0d ready=%b want 0/0/0", bus_s.o_valid, bus_s.o_count, bus_s.o_ready); end
        total++; if (bus_p.o_valid !== 1'b0 || bus_p.o_data !== DW'(0)) begin bad++; $display("FAIL rmid_cleared_p: got valid=%b data=%0h want 0/0", bus_p.o_valid, bus_p.o_data); end
        tick();
        @(negedge clk);
        total++; if (bus_s.o_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready_s: got %b want 1", bus_s.o_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure_skid();
        test_stall();
        test_flush();
        test_backpressure_plain();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register. It is the successor to the fixed-field stage registers between decode/register-read and execute. It carries a control word and a packed data bundle with a valid/ready handshake. It supports stall (hold), flush (bubble insertion) and an optional 2-entry skid buffer that registers the upstream ready path. Every inter-stage boundary in the filter processor pipeline (REG->EXE, EXE->MEM, MEM->WB) instantiates one, with the field bundle packed by the enclosing stage.

Parameters:
CTRL_W, 17, width of the control word
DATA_W, 200, width of the packed data bundle (operands, offsets, immediates, register ids)
SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single register with combinational o_ready
NOP_CTRL, 17'h0, control word driven while the stage holds a bubble

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
i_stall  in  1  hazard-unit hold; no transfer on either side while high
i_flush  in  1  branch/exception flush; invalidates all held entries
i_valid  in  1  upstream entry valid
o_ready  out  1  stage can accept an entry this cycle
i_ctrl  in  CTRL_W  upstream control word
i_data  in  DATA_W  upstream data bundle
o_valid  out  1  downstream entry valid
i_ready  in  1  downstream can accept
o_ctrl  out  CTRL_W  held control word (NOP_CTRL when o_valid=0)
o_data  out  DATA_W  held data bundle
o_count  out  2  occupancy: 0, 1 or 2

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low, named rst_n, sampled on the rising edge of clk.
- Reset (rst_n=0 at posedge): o_valid=0, o_ctrl=NOP_CTRL, o_data=0, o_count=0, skid entry invalid, state EMPTY. With SKID=1, o_ready=0 during the reset cycle and 1 on the first cycle after reset. The same holds when reset is asserted mid-transfer: all entries are lost.
- Handshake terms:
  - acc = i_valid & o_ready
  - dep = o_valid & i_ready & !i_stall
  - An entry transfers only on the clock edge where its handshake is true. Latency is 1 cycle from acc to o_valid.
- Priority: reset > flush > stall > normal operation.
- Flush (i_flush=1 at posedge):
  - Next state EMPTY; o_valid=0; o_ctrl=NOP_CTRL; o_count=0.
  - o_data keeps its old value (don't-care).
  - Any same-cycle acc is dropped, even though o_ready was high.
- Stall (i_stall=1):
  - o_ready=0 combinationally.
  - All registers hold; dep is forced 0.
  - o_valid and o_ctrl keep driving their current values.
- SKID=1 state machine (main register plus skid register):
  - EMPTY (o_valid=0, o_ready=!i_stall): acc -> FULL, main<=input.
  - FULL (o_ready=!i_stall):
    - acc&dep -> FULL, main<=input.
    - acc&!dep -> SKID_FULL, skid<=input.
    - !acc&dep -> EMPTY.
    - else hold.
  - SKID_FULL (o_ready=0): dep -> FULL, main<=skid; else hold.
  - o_ready is a registered state decode gated only by i_stall. It has no combinational path from i_ready.
- SKID=0:
  - o_ready = (!o_valid | i_ready) & !i_stall, combinational.
  - acc loads main; dep without acc -> o_valid=0.
  - o_count is never 2.
- o_ctrl is forced to NOP_CTRL whenever o_valid=0, so downstream units see a bubble with no side effects. This includes no register-file write.
- Ordering: entries leave in acceptance order. There is no duplication and no loss except on flush or reset.
- Data registers load only on an accepting transfer; otherwise they hold. This avoids toggling on bubbles.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_W and NOP_CTRL.
  - Per-stage bundle widths (REG_EXE_DATA_W = 4+4+32*7 and so on).
  - Occupancy state encoding (EMPTY/FULL/SKID_FULL).
- One natural sub-module: pipe_skid_buf, the 2-entry storage plus state machine. pipe_stage_reg instantiates it when SKID=1, or a plain register when SKID=0, via a generate branch. Stall/flush gating and the NOP substitution stay in the top.

Test Plan:
- Reset: rst_n=0 for 2 cycles with i_valid=1, i_ctrl=17'h1ABCD -> o_valid=0, o_ctrl=0, o_count=0. One cycle after release, o_ready=1.
- Streaming: i_valid=1 and i_ready=1 continuously, i_data=1..8 -> o_data=1..8 in order, each 1 cycle after acceptance, o_count=1 throughout, no gaps.
- Backpressure (SKID=1): send entries A and B, deassert i_ready after A is loaded -> o_count=2, o_ready=0, A held on o_data. Re-assert i_ready -> A, then B, on consecutive cycles; o_ready returns to 1 one cycle after A leaves.
- Stall: i_stall=1 for 3 cycles while FULL with i_ready=1 -> o_valid and o_data unchanged, o_ready=0, no entry consumed. Release -> entry departs on the next edge.
- Flush: in SKID_FULL, pulse i_flush with i_valid=1 -> next cycle o_valid=0, o_ctrl=NOP_CTRL, o_count=0, the new input dropped. The following entry is accepted normally.
- SKID=0 build: repeat the streaming and backpressure tests -> o_ready follows i_ready combinationally within the cycle, o_count never exceeds 1, identical output order.
